// File: rtl/ysyx_22040125_halt_ctrl.sv
// Halt controller: prioritised halt requests travel a DELAY-stage line and latch a sticky halted state.
// Optional YSYX_22040125_HALT_CNT_EN adds a saturating 16-bit halt counter; otherwise halt_cnt_o is tied to 0.
module ysyx_22040125_halt_ctrl #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    evt_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              clr_i,
  output logic              halt_o,
  output logic              halt_pulse_o,
  output logic [2:0]        halt_ch_o,
  output logic [CODE_W-1:0] halt_code_o,
  output logic [15:0]       halt_cnt_o
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [DELAY-1:0]             vld_q, vld_d;
  logic [DELAY-1:0][2:0]        ch_q, ch_d;
  logic [DELAY-1:0][CODE_W-1:0] code_q, code_d;
  logic [2:0]                   hch_q, hch_d;
  logic [CODE_W-1:0]            hcode_q, hcode_d;
  logic [2:0]                   evt_ch;
  logic                         take;

  // Scan from the top so the lowest asserted channel is the last one written.
  always_comb begin
    evt_ch = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (evt_i[i-1]) evt_ch = 3'(i - 1);
    end
  end

  // A valid last stage in RUN is the halt-entry cycle; the state register flips at the next edge.
  assign take = (state_q == ST_RUN) && vld_q[DELAY-1];

  always_comb begin
    state_d   = state_q;
    vld_d     = '0;
    ch_d      = ch_q;
    code_d    = code_q;
    hch_d     = hch_q;
    hcode_d   = hcode_q;
    ch_d[0]   = evt_ch;
    code_d[0] = code_i;
    for (int unsigned i = 1; i < DELAY; i++) begin
      ch_d[i]   = ch_q[i-1];
      code_d[i] = code_q[i-1];
    end
    case (state_q)
      ST_RUN: begin
        if (take) begin
          state_d = ST_HALTED;
          hch_d   = ch_q[DELAY-1];
          hcode_d = code_q[DELAY-1];
        end else begin
          vld_d[0] = |evt_i;
          for (int unsigned i = 1; i < DELAY; i++) begin
            vld_d[i] = vld_q[i-1];
          end
        end
      end
      ST_HALTED: begin
        if (clr_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      vld_q   <= '0;
      ch_q    <= '0;
      code_q  <= '0;
      hch_q   <= '0;
      hcode_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      ch_q    <= ch_d;
      code_q  <= code_d;
      hch_q   <= hch_d;
      hcode_q <= hcode_d;
    end
  end

  // During the entry cycle the captured values come straight from the last stage.
  assign halt_pulse_o = take;
  assign halt_o       = (state_q == ST_HALTED) || take;
  assign halt_ch_o    = take ? ch_q[DELAY-1]   : hch_q;
  assign halt_code_o  = take ? code_q[DELAY-1] : hcode_q;

`ifdef YSYX_22040125_HALT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (take && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign halt_cnt_o = cnt_q;
`else
  assign halt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040125_halt_ctrl.sv
// Bench for ysyx_22040125_halt_ctrl: DELAY=2 and DELAY=3 instances share directed stimulus,
// checked every cycle against a timestamped request-queue model plus literal expectations.
module tb_ysyx_22040125_halt_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] evt = '0;
  logic [7:0] code = '0;
  logic       clr = 1'b0;

  logic       a_halt, a_pulse, b_halt, b_pulse;
  logic [2:0] a_ch, b_ch;
  logic [7:0] a_code, b_code;
  logic [15:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef YSYX_22040125_HALT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_22040125_halt_ctrl #(.NCH(2), .DELAY(2), .CODE_W(8)) dut_a (
    .clk(clk), .rst(rst), .evt_i(evt), .code_i(code), .clr_i(clr),
    .halt_o(a_halt), .halt_pulse_o(a_pulse), .halt_ch_o(a_ch),
    .halt_code_o(a_code), .halt_cnt_o(a_cnt)
  );

  ysyx_22040125_halt_ctrl #(.NCH(2), .DELAY(3), .CODE_W(8)) dut_b (
    .clk(clk), .rst(rst), .evt_i(evt), .code_i(code), .clr_i(clr),
    .halt_o(b_halt), .halt_pulse_o(b_pulse), .halt_ch_o(b_ch),
    .halt_code_o(b_code), .halt_cnt_o(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: each request is due DELAY-1 edges after the edge that sampled it.
  typedef struct {
    int         due;
    logic [2:0] ch;
    logic [7:0] code;
  } req_t;

  req_t       q0[$];
  req_t       q1[$];
  int         dly[2] = '{2, 3};
  bit         m_halted[2];
  bit         m_pulse[2];
  logic [2:0] m_ch[2];
  logic [7:0] m_code[2];
  int         m_cnt[2];
  bit         e_halt[2];
  logic [2:0] e_ch[2];
  logic [7:0] e_code[2];

  function automatic logic [2:0] lowest(input logic [1:0] v);
    for (int k = 0; k < 2; k++) if (v[k]) return 3'(k);
    return 3'd0;
  endfunction

  task automatic model_step(input int d);
    req_t qq[$];
    req_t r;
    if (d == 0) qq = q0; else qq = q1;
    if (rst) begin
      m_halted[d] = 1'b0;
      qq.delete();
      m_ch[d] = '0;
      m_code[d] = '0;
      m_cnt[d] = 0;
    end else if (m_halted[d]) begin
      if (clr) m_halted[d] = 1'b0;
    end else if (m_pulse[d]) begin
      m_halted[d] = 1'b1;
      m_ch[d] = qq[0].ch;
      m_code[d] = qq[0].code;
      if (m_cnt[d] < 65535) m_cnt[d]++;
      qq.delete();
    end else if (evt != 2'b00) begin
      r.due = cyc + dly[d] - 1;
      r.ch = lowest(evt);
      r.code = code;
      qq.push_back(r);
    end
    m_pulse[d] = !m_halted[d] && (qq.size() > 0) && (qq[0].due == cyc);
    e_halt[d] = m_halted[d] || m_pulse[d];
    e_ch[d]   = m_pulse[d] ? qq[0].ch : m_ch[d];
    e_code[d] = m_pulse[d] ? qq[0].code : m_code[d];
    if (d == 0) q0 = qq; else q1 = qq;
  endtask

  // Compare process: inputs are stable at negedge, so they are the ones the last posedge sampled.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) model_step(d);
      chk("A.halt_o", a_halt, e_halt[0]);
      chk("A.halt_pulse_o", a_pulse, m_pulse[0]);
      chk("A.halt_ch_o", a_ch, e_ch[0]);
      chk("A.halt_code_o", a_code, e_code[0]);
      chk("A.halt_cnt_o", a_cnt, CNT_EN ? m_cnt[0] : 0);
      chk("B.halt_o", b_halt, e_halt[1]);
      chk("B.halt_pulse_o", b_pulse, m_pulse[1]);
      chk("B.halt_ch_o", b_ch, e_ch[1]);
      chk("B.halt_code_o", b_code, e_code[1]);
      chk("B.halt_cnt_o", b_cnt, CNT_EN ? m_cnt[1] : 0);
    end
  end

  // One posedge per call; returns 1 time unit after the following negedge.
  task automatic step(input logic [1:0] e, input logic [7:0] c, input logic k, input logic r);
    evt = e;
    code = c;
    clr = k;
    rst = r;
    @(negedge clk);
    #1;
  endtask

  task automatic release_both();
    repeat (3) step(2'b00, 8'h00, 1'b1, 1'b0);
    repeat (2) step(2'b00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("reset_halt", a_halt, 0);
    chk("reset_pulse", a_pulse, 0);
    chk("reset_ch", a_ch, 0);
    chk("reset_code", a_code, 0);
    chk("reset_cnt", a_cnt, 0);
    step(2'b00, 8'h00, 1'b0, 1'b0);

    // Single ebreak request, DELAY=2.
    step(2'b01, 8'h2A, 1'b0, 1'b0);
    chk("t029_early_halt", a_halt, 0);
    step(2'b00, 8'h00, 1'b0, 1'b0);
    chk("t029_halt", a_halt, 1);
    chk("t029_pulse", a_pulse, 1);
    chk("t029_ch", a_ch, 0);
    chk("t029_code", a_code, 8'h2A);
    step(2'b00, 8'h00, 1'b0, 1'b0);
    chk("t029_pulse_low", a_pulse, 0);
    chk("t029_sticky", a_halt, 1);
    release_both();

    // Simultaneous requests: lowest index wins.
    step(2'b11, 8'h05, 1'b0, 1'b0);
    step(2'b00, 8'h00, 1'b0, 1'b0);
    chk("t030_pulse", a_pulse, 1);
    chk("t030_ch", a_ch, 0);
    chk("t030_code", a_code, 8'h05);
    release_both();

    // Back-to-back requests: one halt, then clear with no second halt.
    step(2'b01, 8'h11, 1'b0, 1'b0);
    step(2'b10, 8'h22, 1'b0, 1'b0);
    chk("t031_pulse", a_pulse, 1);
    chk("t031_ch", a_ch, 0);
    chk("t031_code", a_code, 8'h11);
    step(2'b00, 8'h00, 1'b0, 1'b0);
    chk("t031_halted", a_halt, 1);
    step(2'b00, 8'h00, 1'b1, 1'b0);
    chk("t031_cleared", a_halt, 0);
    chk("t031_keep_code", a_code, 8'h11);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'h00, 1'b0, 1'b0);
      chk("t031_no_second_halt", a_halt, 0);
      chk("t031_no_second_pulse", a_pulse, 0);
    end
    release_both();

    // Requests while halted are ignored.
    step(2'b01, 8'h33, 1'b0, 1'b0);
    step(2'b00, 8'h00, 1'b0, 1'b0);
    chk("t032_pulse", a_pulse, 1);
    for (int i = 0; i < 5; i++) begin
      step(2'b01, 8'h77, 1'b0, 1'b0);
      chk("t032_halt_held", a_halt, 1);
      chk("t032_no_pulse", a_pulse, 0);
      chk("t032_code_kept", a_code, 8'h33);
    end
    release_both();

    // Reset one cycle after a request discards it (DELAY=3 instance).
    step(2'b01, 8'h44, 1'b0, 1'b0);
    step(2'b00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 8'h00, 1'b0, 1'b0);
      chk("t033_b_halt", b_halt, 0);
      chk("t033_b_pulse", b_pulse, 0);
      chk("t033_a_halt", a_halt, 0);
    end
    chk("t033_b_ch", b_ch, 0);
    chk("t033_b_code", b_code, 0);
    chk("t033_b_cnt", b_cnt, 0);

    // Three halt/clear rounds from a fresh reset.
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 8'(8'h50 + i), 1'b0, 1'b0);
      step(2'b00, 8'h00, 1'b0, 1'b0);
      chk("t034_pulse", a_pulse, 1);
      release_both();
    end
`ifdef YSYX_22040125_HALT_CNT_EN
    chk("t034_a_cnt", a_cnt, 3);
    chk("t034_b_cnt", b_cnt, 3);
`else
    chk("t034_a_cnt", a_cnt, 0);
    chk("t034_b_cnt", b_cnt, 0);
`endif

    step(2'b00, 8'h00, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
